time_display_scan: RTL and testbench

// Reader/consumer end of the clock datapath: takes the six BCD time digits produced by

---
 rtl/time_display_scan_pkg.sv | 43 ++++
 rtl/time_display_scan_bcd_to_seg7.sv | 29 ++
 rtl/time_display_scan.sv | 131 +++++++++++++
 tb/tb_time_display_scan.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/time_display_scan_pkg.sv
// Shared constants and types for the 6-digit multiplexed time display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package time_display_scan_pkg;

   localparam int NUM_DIGITS = 6;

   // Slot positions, right to left on the display
   localparam logic [2:0] SLOT_SEC_1  = 3'd0;
   localparam logic [2:0] SLOT_SEC_2  = 3'd1;
   localparam logic [2:0] SLOT_MIN_1  = 3'd2;
   localparam logic [2:0] SLOT_MIN_2  = 3'd3;
   localparam logic [2:0] SLOT_HOUR_1 = 3'd4;
   localparam logic [2:0] SLOT_HOUR_2 = 3'd5;

   // Colon dots sit after minutes-units and hours-units
   localparam logic [2:0] COLON_SLOT_A = SLOT_MIN_1;
   localparam logic [2:0] COLON_SLOT_B = SLOT_HOUR_1;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef logic [3:0] bcd_t;

   // Per-frame snapshot of everything the scan displays
   typedef struct packed {
      bcd_t [NUM_DIGITS-1:0] dig;
      logic [NUM_DIGITS-1:0] blink;
      logic                  dp_en;
   } snap_t;

endpackage

// File: rtl/time_display_scan_bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
   import time_display_scan_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Table lookup, codes A..F fall through to the dash
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/time_display_scan.sv
// Scans six BCD time digits onto a multiplexed 7-seg display, one slot per scan tick.
// Latency: pins show the new slot 1 clk after its tick; inputs take effect at the next frame snapshot.
// Backpressure: none; free-running scan, inputs are sampled only at frame wrap.
module time_display_scan
   import time_display_scan_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int BLINK_DIV      = 83,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit LEAD_BLANK     = 1'b1
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_sec_1,
   input  logic [3:0] i_sec_2,
   input  logic [3:0] i_min_1,
   input  logic [3:0] i_min_2,
   input  logic [3:0] i_hour_1,
   input  logic [3:0] i_hour_2,
   input  logic [5:0] i_blink_mask,
   input  logic       i_dp_en,
   output logic [5:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp,
   output logic       o_frame_start
);

   localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW  ? 6'h3F : 6'h00;
   localparam logic [6:0] SEG_PIN_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic          r_started;
   logic [FW-1:0] r_frame_cnt;
   logic          r_blink_phase;
   snap_t         r_snap;
   logic [5:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic          r_frame_start;

   logic          w_tick;
   logic          w_wrap;
   logic [2:0]    w_idx_nxt;
   snap_t         w_snap_in;
   snap_t         w_snap_nxt;
   logic          w_phase_nxt;
   logic [6:0]    w_seg_raw;
   logic          w_blank;
   logic          w_dp_on;
   logic [5:0]    w_an_on;

   // A frame wraps on the tick leaving slot 5, and on the very first tick after reset
   assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
   assign w_wrap      = w_tick && (!r_started || (r_idx == SLOT_HOUR_2));
   assign w_idx_nxt   = w_wrap ? SLOT_SEC_1 : (w_tick ? r_idx + 3'd1 : r_idx);
   assign w_snap_nxt  = w_wrap ? w_snap_in : r_snap;
   assign w_phase_nxt = (w_wrap && (r_frame_cnt == FW'(BLINK_DIV - 1))) ? ~r_blink_phase
                                                                         : r_blink_phase;

   // Gather the live inputs into snapshot form, slot order matches an[]
   always_comb begin
      w_snap_in       = '0;
      w_snap_in.dig   = {i_hour_2, i_hour_1, i_min_2, i_min_1, i_sec_2, i_sec_1};
      w_snap_in.blink = i_blink_mask;
      w_snap_in.dp_en = i_dp_en;
   end

   // Decode from the post-tick view so slot 0 of a new frame already uses the new snapshot
   bcd_to_seg7 u_dec (
      .i_bcd (w_snap_nxt.dig[w_idx_nxt]),
      .o_seg (w_seg_raw)
   );

   assign w_blank = (w_phase_nxt && w_snap_nxt.blink[w_idx_nxt]) ||
                    (LEAD_BLANK && (w_idx_nxt == SLOT_HOUR_2) && (w_snap_nxt.dig[SLOT_HOUR_2] == 4'd0));
   assign w_dp_on = !w_blank && w_snap_nxt.dp_en &&
                    ((w_idx_nxt == COLON_SLOT_A) || (w_idx_nxt == COLON_SLOT_B));
   assign w_an_on = w_blank ? 6'h00 : (6'd1 << w_idx_nxt);

   // Prescaler, slot counter, blink counter and frame snapshot
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc       <= '0;
         r_idx         <= '0;
         r_started     <= 1'b0;
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_snap        <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            r_idx     <= w_idx_nxt;
            r_started <= 1'b1;
         end
         if (w_wrap) begin
            r_snap        <= w_snap_in;
            r_blink_phase <= w_phase_nxt;
            r_frame_cnt   <= (r_frame_cnt == FW'(BLINK_DIV - 1)) ? '0 : r_frame_cnt + FW'(1);
         end
      end
   end

   // Pin registers: reload on tick with polarity applied, hold between ticks
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_an          <= AN_OFF;
         r_seg         <= SEG_PIN_OFF;
         r_dp          <= DP_OFF;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_wrap;
         if (w_tick) begin
            r_an  <= w_an_on ^ {6{AN_ACTIVE_LOW}};
            r_seg <= (w_blank ? SEG_OFF : w_seg_raw) ^ {7{SEG_ACTIVE_LOW}};
            r_dp  <= w_dp_on ^ SEG_ACTIVE_LOW;
         end
      end
   end

   assign o_an          = r_an;
   assign o_seg         = r_seg;
   assign o_dp          = r_dp;
   assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: directed scenarios then random digits/blink/reset vs a time-based model.
// Latency: model expects pins to change 1 clk after each 4-clk slot boundary.
// Backpressure: none.
module tb_time_display_scan;

   localparam int SD = 4;
   localparam int BD = 2;

   logic       clk;
   logic       rst;
   logic [3:0] dig [6];
   logic [5:0] blink;
   logic       dp_en;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   int checks = 0;
   int errors = 0;

   time_display_scan #(
      .SCAN_DIV       (SD),
      .BLINK_DIV      (BD),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1),
      .LEAD_BLANK     (1'b1)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sec_1       (dig[0]),
      .i_sec_2       (dig[1]),
      .i_min_1       (dig[2]),
      .i_min_2       (dig[3]),
      .i_hour_1      (dig[4]),
      .i_hour_2      (dig[5]),
      .i_blink_mask  (blink),
      .i_dp_en       (dp_en),
      .o_an          (an),
      .o_seg         (seg),
      .o_dp          (dp),
      .o_frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [6:0] seg_tbl [10];
   initial seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic logic [6:0] pattern(input logic [3:0] d);
      return (d < 4'd10) ? seg_tbl[d] : 7'h40;
   endfunction

   // Reference model: everything derived from the number of clock edges since reset release.
   int         n_edges;
   logic [3:0] s_dig [6];
   logic [5:0] s_blink;
   logic       s_dp;
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;
   logic       e_fs;

   always @(posedge clk) begin
      int t, slot, frame, phase;
      bit blank;
      if (rst) begin
         n_edges = 0;
         e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
      end else begin
         n_edges++;
         e_fs = 1'b0;
         if (n_edges % SD == 0) begin
            t     = n_edges / SD;
            slot  = (t - 1) % 6;
            frame = (t - 1) / 6;
            if (slot == 0) begin
               s_dig   = dig;
               s_blink = blink;
               s_dp    = dp_en;
               e_fs    = 1'b1;
            end
            // phase flips on every BD-th frame wrap, counting the first wrap as wrap 1
            phase = ((frame + 1) / BD) % 2;
            blank = (phase == 1 && s_blink[slot]) || (slot == 5 && s_dig[5] == 4'd0);
            if (blank) begin
               e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
               e_an  = 6'h3F & ~(6'd1 << slot);
               e_seg = ~pattern(s_dig[slot]);
               e_dp  = !(s_dp && (slot == 2 || slot == 4));
            end
         end
      end
      #1;
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
   end

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic set_time(input int h2, h1, m2, m1, s2, s1);
      dig[5] = 4'(h2); dig[4] = 4'(h1); dig[3] = 4'(m2);
      dig[2] = 4'(m1); dig[1] = 4'(s2); dig[0] = 4'(s1);
   endtask

   initial begin
      bit found;
      rst = 1'b1; blink = 6'h00; dp_en = 1'b1;
      set_time(1, 2, 3, 4, 5, 6);
      cycles(3);
      rst = 1'b0;
      // static 12:34:56 with colons
      cycles(60);
      // mid-frame minute change shows only after the next snapshot
      cycles(10);
      dig[2] = 4'd7;
      cycles(60);
      // leading hour zero blanked, then restored
      dig[5] = 4'd0;
      cycles(60);
      dig[5] = 4'd1;
      cycles(60);
      // blink the seconds slots over several phases
      blink = 6'h03;
      cycles(24 * 6);
      blink = 6'h00;
      // non-decimal code shows a dash
      dig[0] = 4'hC;
      cycles(60);
      // reset in the middle of slot 3
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (an == 6'h37) found = 1'b1;
      end
      chk("slot3_seen", 32'(found), 32'd1);
      cycles(1);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(30);
      // random digits, blink masks, colons and occasional resets
      for (int it = 0; it < 60; it++) begin
         for (int d = 0; d < 6; d++) dig[d] = 4'($urandom_range(15, 0));
         if ($urandom_range(3, 0) == 0) dig[5] = 4'd0;
         blink = ($urandom_range(2, 0) == 0) ? 6'($urandom) : 6'h00;
         dp_en = 1'($urandom);
         if ($urandom_range(15, 0) == 0) begin
            rst = 1'b1;
            cycles(1);
            rst = 1'b0;
         end
         cycles($urandom_range(40, 1));
      end
      cycles(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
